fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage and IF/ID pipeline register of the 5-stage core, directly upstream of the hazard unit.
- Consumes the hazard unit's stallF, stallD and flushD, plus the branch target resolved in D.
- Owns the PC and runs a req/rdy handshake to instruction memory that may take several cycles.
- Delivers instrD, pcD and pc_plus2D to decode; detects HALT and freezes fetch.

Parameters:
ADDR_W, 16, PC and instruction-memory address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OP, 4'hF, opcode in instr[15:12] that halts fetch

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
stallF  in  1  from hazard: freeze PC, start no new fetch
stallD  in  1  from hazard: hold IF/ID contents
flushD  in  1  from hazard: branch taken in D; redirect and bubble IF/ID
branch_targetD  in  ADDR_W  redirect PC, valid when flushD=1
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
imem_rdy  in  1  completes the transaction; may be same cycle as req
imem_data  in  INSTR_W  instruction, valid when imem_rdy=1
instrD  out  INSTR_W  instruction in D
pcD  out  ADDR_W  address of instrD
pc_plus2D  out  ADDR_W  pcD+2
validD  out  1  instrD is a real instruction (0 = bubble)
haltF  out  1  fetch halted

Behaviour:
- Reset (rst_n=0 at edge):
  - pcF=RESET_PC; state=FETCH.
  - instrD=0, pcD=0, pc_plus2D=0, validD=0, haltF=0.
  - Holding buffer empty; any in-flight transaction abandoned.
  - imem_req=0 during the reset cycle.
- States: FETCH, WAIT (transaction outstanding), SQUASH (outstanding, result discarded), HALT.
- Transaction rules:
  - A transaction starts when imem_req=1 in FETCH.
  - imem_req=1 in FETCH when ~stallF and the holding buffer is empty.
  - imem_addr is latched into req_addr at start and held until imem_rdy. imem_req must not drop mid-transaction.
  - Start cycle with imem_rdy=1: completes same cycle (zero-wait, one instr/cycle throughput).
  - Start cycle with imem_rdy=0: go to WAIT. In WAIT, req stays 1 and addr stays req_addr.
- Completion (imem_rdy=1 in FETCH or WAIT, no flushD):
  - pcF += 2, modulo 2^ADDR_W.
  - If stallD=1, the word and its address go to a 1-entry holding buffer.
  - Otherwise the word loads IF/ID.
  - Return to FETCH.
  - If imem_data[15:12]==HALT_OP: the word is still delivered, pcF is NOT incremented, state=HALT, haltF=1.
- IF/ID update, priority order:
  - flushD: validD=0, instrD=0.
  - stallD: hold all outputs.
  - Holding buffer full: load from buffer, validD=1, buffer emptied.
  - Completion this cycle: load imem_data; pcD=req_addr; pc_plus2D=req_addr+2; validD=1.
  - Otherwise: bubble, validD=0, instrD=0.
- stallF: pcF frozen and no new start. It does not affect an outstanding transaction.
- flushD (overrides stallF and stallD):
  - pcF=branch_targetD; holding buffer cleared; haltF=0.
  - In HALT: state becomes FETCH.
  - In WAIT with imem_rdy=0: state becomes SQUASH.
  - Completion in the same cycle: the returned word is discarded and state=FETCH.
- SQUASH: req held at the old req_addr. On imem_rdy the data is dropped and state=FETCH; the next transaction uses the redirected pcF.
- HALT: imem_req=0; IF/ID drains to bubbles once stallD releases. Exits only on flushD or reset.
- Reset mid-transaction: returns to FETCH/RESET_PC; memory must tolerate the abandoned request.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched[31:0] (count of words loaded into IF/ID with validD=1) and perf_bubbles[31:0] (count of cycles IF/ID loaded a bubble, flush included). Both are 0 on reset and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Zero-wait memory (rdy tied 1), program 0x1111,0x2222,0x3333 at 0,2,4 -> validD=1 on three consecutive cycles; pcD=0,2,4; pc_plus2D=2,4,6.
- rdy delayed 3 cycles for addr 0x0002 -> imem_req and imem_addr=0x0002 held 3 cycles; validD=0 those cycles; instr delivered on the cycle after rdy.
- stallF=stallD=1 for 2 cycles while fetching 0x0004 with zero-wait -> word buffered; pcF holds 0x0006; IF/ID unchanged; after release instrD=word@4 with no refetch of 4.
- flushD with branch_targetD=0x0040 while WAIT on 0x0008 -> SQUASH; word@8 never reaches D; next imem_addr=0x0040; validD=0 on the flush cycle.
- HALT (0xF000) fetched at 0x000C -> haltF=1, imem_req=0, pcF=0x000C; later flushD to 0x0020 -> haltF=0 and fetch resumes at 0x0020.
- rst_n=0 for one cycle during WAIT -> next cycle pcF=RESET_PC, validD=0, haltF=0; with FETCH_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface fetch_stage_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rdy;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: owns the PC, runs the imem req/rdy handshake, halts on HALT_OP.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               flushD,
    input  logic [ADDR_W-1:0]  branch_targetD,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] instrD,
    output logic [ADDR_W-1:0]  pcD,
    output logic [ADDR_W-1:0]  pc_plus2D,
    output logic               validD,
    output logic               haltF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);

    typedef enum logic [1:0] {StFetch, StWait, StSquash, StHalt} state_e;

    state_e             state, stateNext;
    logic [ADDR_W-1:0]  pcF, pcFNext;
    logic [ADDR_W-1:0]  reqAddr, reqAddrNext;
    logic               bufValid, bufValidNext;
    logic [INSTR_W-1:0] bufInstr, bufInstrNext;
    logic [ADDR_W-1:0]  bufPc, bufPcNext;
    logic [INSTR_W-1:0] instrDNext;
    logic [ADDR_W-1:0]  pcDNext, pcPlus2DNext;
    logic               validDNext, haltFNext;

    logic               fetchReq, start, complete, isHalt, rdy;
    logic [ADDR_W-1:0]  curAddr;

    always_comb begin
        fetchReq = 1'b0;
        case (state)
            StFetch:          fetchReq = ~stallF & ~bufValid;
            StWait, StSquash: fetchReq = 1'b1;
            default:          fetchReq = 1'b0;
        endcase
    end

    // Request is forced low while reset is asserted so no transaction starts in the reset cycle.
    assign imem.imem_req  = rst_n & fetchReq;
    assign curAddr        = (state == StFetch) ? pcF : reqAddr;
    assign imem.imem_addr = curAddr;
    assign rdy            = imem.imem_rdy;
    assign start          = (state == StFetch) & fetchReq;
    assign complete       = rdy & (start | (state == StWait));
    assign isHalt         = (imem.imem_data[INSTR_W-1 -: 4] == HALT_OP);

    always_comb begin
        stateNext    = state;
        pcFNext      = pcF;
        reqAddrNext  = reqAddr;
        bufValidNext = bufValid;
        bufInstrNext = bufInstr;
        bufPcNext    = bufPc;
        instrDNext   = instrD;
        pcDNext      = pcD;
        pcPlus2DNext = pc_plus2D;
        validDNext   = validD;
        haltFNext    = haltF;

        if (start) begin
            reqAddrNext = pcF;
        end

        if (flushD) begin
            pcFNext      = branch_targetD;
            bufValidNext = 1'b0;
            haltFNext    = 1'b0;
            // An outstanding request cannot be withdrawn; drain it in StSquash.
            if ((start || state == StWait || state == StSquash) && !rdy) begin
                stateNext = StSquash;
            end else begin
                stateNext = StFetch;
            end
        end else begin
            case (state)
                StFetch:  if (start && !rdy) stateNext = StWait;
                StSquash: if (rdy) stateNext = StFetch;
                default:  ;
            endcase
            if (complete) begin
                if (isHalt) begin
                    stateNext = StHalt;
                    haltFNext = 1'b1;
                end else begin
                    pcFNext   = pcF + ADDR_W'(2);
                    stateNext = StFetch;
                end
                if (stallD) begin
                    bufValidNext = 1'b1;
                    bufInstrNext = imem.imem_data;
                    bufPcNext    = curAddr;
                end
            end
        end

        if (flushD) begin
            validDNext = 1'b0;
            instrDNext = '0;
        end else if (stallD) begin
            validDNext = validD;
        end else if (bufValid) begin
            instrDNext   = bufInstr;
            pcDNext      = bufPc;
            pcPlus2DNext = bufPc + ADDR_W'(2);
            validDNext   = 1'b1;
            bufValidNext = 1'b0;
        end else if (complete) begin
            instrDNext   = imem.imem_data;
            pcDNext      = curAddr;
            pcPlus2DNext = curAddr + ADDR_W'(2);
            validDNext   = 1'b1;
        end else begin
            validDNext = 1'b0;
            instrDNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StFetch;
            pcF       <= RESET_PC;
            reqAddr   <= RESET_PC;
            bufValid  <= 1'b0;
            bufInstr  <= '0;
            bufPc     <= '0;
            instrD    <= '0;
            pcD       <= '0;
            pc_plus2D <= '0;
            validD    <= 1'b0;
            haltF     <= 1'b0;
        end else begin
            state     <= stateNext;
            pcF       <= pcFNext;
            reqAddr   <= reqAddrNext;
            bufValid  <= bufValidNext;
            bufInstr  <= bufInstrNext;
            bufPc     <= bufPcNext;
            instrD    <= instrDNext;
            pcD       <= pcDNext;
            pc_plus2D <= pcPlus2DNext;
            validD    <= validDNext;
            haltF     <= haltFNext;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic loadValid, loadBubble;
    assign loadValid  = ~flushD & ~stallD & (bufValid | complete);
    assign loadBubble = flushD | (~stallD & ~bufValid & ~complete);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (loadValid) perf_fetched <= perf_fetched + 32'd1;
            if (loadBubble) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run scored
// against a program-order model (deliveries follow pc, pc+2, ... restarting at each flush target).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stallF = 1'b0;
    logic        stallD = 1'b0;
    logic        flushD = 1'b0;
    logic [15:0] branch_targetD = 16'h0;
    logic [15:0] instrD, pcD, pc_plus2D;
    logic        validD, haltF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) mif ();

    fetch_stage #(
        .ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .HALT_OP(4'hF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .branch_targetD(branch_targetD), .imem(mif), .instrD(instrD), .pcD(pcD),
        .pc_plus2D(pc_plus2D), .validD(validD), .haltF(haltF)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model with configurable latency.
    logic [15:0] mem [0:32767];
    int          memWait = 0;
    int          memLat = 0;
    int          fixedLat = 0;
    bit          randLat = 1'b0;
    logic [15:0] delayAddr = 16'hFFFF;
    int          delayCycles = 0;
    logic        memReady;

    always_comb begin
        memReady = 1'b0;
        if (mif.imem_req) begin
            memReady = (memWait >= ((mif.imem_addr == delayAddr) ? delayCycles : memLat));
        end
        mif.imem_rdy  = memReady;
        mif.imem_data = memReady ? mem[mif.imem_addr[15:1]] : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (!rst_n || !mif.imem_req || mif.imem_rdy) begin
            memWait <= 0;
            memLat  <= randLat ? int'($urandom_range(0, 3)) : fixedLat;
        end else begin
            memWait <= memWait + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic fill_mem();
        logic [15:0] w;
        for (int i = 0; i < 32768; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h3;
            mem[i] = w;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        checks++; if (mif.imem_req !== 1'b0) begin errors++;
            $display("FAIL reset_req: got %b want 0", mif.imem_req); end
        cyc();
        checks++; if ({validD, haltF} !== 2'b00) begin errors++;
            $display("FAIL reset_flags: validD=%b haltF=%b want 0 0", validD, haltF); end
        checks++; if ({instrD, pcD, pc_plus2D} !== 48'h0) begin errors++;
            $display("FAIL reset_ifid: instr=%h pc=%h p2=%h want 0", instrD, pcD, pc_plus2D); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if ({perf_fetched, perf_bubbles} !== 64'h0) begin errors++;
            $display("FAIL reset_perf: %0d %0d want 0 0", perf_fetched, perf_bubbles); end
`endif
        rst_n = 1'b1; #1;
        checks++; if ({mif.imem_req, mif.imem_addr} !== {1'b1, 16'h0000}) begin errors++;
            $display("FAIL reset_first_req: req=%b addr=%h want 1 0000", mif.imem_req,
                     mif.imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [15:0] exp [3];
        exp[0] = 16'h1111; exp[1] = 16'h2222; exp[2] = 16'h3333;
        mem[0] = exp[0]; mem[1] = exp[1]; mem[2] = exp[2];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({validD, instrD, pcD, pc_plus2D} !== {1'b1, exp[i], 16'(2 * i), 16'(2 * i + 2)})
            begin
                errors++;
                $display("FAIL zero_wait[%0d]: v=%b i=%h pc=%h p2=%h want 1 %h %h %h", i, validD,
                         instrD, pcD, pc_plus2D, exp[i], 16'(2 * i), 16'(2 * i + 2));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        checks++; if ({perf_fetched, perf_bubbles} !== {32'd3, 32'd0}) begin errors++;
            $display("FAIL perf_zero_wait: %0d %0d want 3 0", perf_fetched, perf_bubbles); end
`endif
    endtask

    task automatic test_wait_state();
        delayAddr = 16'h0002; delayCycles = 3;
        do_reset();
        cyc();
        checks++; if ({validD, pcD} !== {1'b1, 16'h0000}) begin errors++;
            $display("FAIL wait_first: v=%b pc=%h want 1 0000", validD, pcD); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({mif.imem_req, mif.imem_addr} !== {1'b1, 16'h0002}) begin errors++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h want 1 0002", i, mif.imem_req,
                         mif.imem_addr); end
            cyc();
            checks++; if (validD !== 1'b0) begin errors++;
                $display("FAIL wait_bubble[%0d]: v=%b want 0", i, validD); end
        end
        cyc();
        checks++; if ({validD, pcD, pc_plus2D, instrD} !== {1'b1, 16'h0002, 16'h0004, mem[1]})
        begin errors++;
            $display("FAIL wait_deliver: v=%b pc=%h p2=%h i=%h want 1 0002 0004 %h", validD, pcD,
                     pc_plus2D, instrD, mem[1]); end
        delayAddr = 16'hFFFF;
    endtask

    task automatic test_stall_buffer();
        do_reset();
        cyc(); cyc();
        stallD = 1'b1;
        cyc();
        checks++; if ({validD, pcD, instrD} !== {1'b1, 16'h0002, mem[1]}) begin errors++;
            $display("FAIL stall_hold: v=%b pc=%h i=%h want 1 0002 %h", validD, pcD, instrD,
                     mem[1]); end
        stallF = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (mif.imem_req !== 1'b0) begin errors++;
                $display("FAIL stall_noreq[%0d]: req=%b want 0", i, mif.imem_req); end
            cyc();
        end
        checks++; if (pcD !== 16'h0002) begin errors++;
            $display("FAIL stall_ifid: pc=%h want 0002", pcD); end
        stallF = 1'b0; stallD = 1'b0; #1;
        checks++; if (mif.imem_req !== 1'b0) begin errors++;
            $display("FAIL stall_norefetch: req=%b want 0", mif.imem_req); end
        cyc();
        checks++; if ({validD, pcD, pc_plus2D, instrD} !== {1'b1, 16'h0004, 16'h0006, mem[2]})
        begin errors++;
            $display("FAIL stall_release: v=%b pc=%h p2=%h i=%h want 1 0004 0006 %h", validD, pcD,
                     pc_plus2D, instrD, mem[2]); end
        #1;
        checks++; if ({mif.imem_req, mif.imem_addr} !== {1'b1, 16'h0006}) begin errors++;
            $display("FAIL stall_nextaddr: req=%b addr=%h want 1 0006", mif.imem_req,
                     mif.imem_addr); end
        cyc();
        checks++; if ({validD, pcD} !== {1'b1, 16'h0006}) begin errors++;
            $display("FAIL stall_next: v=%b pc=%h want 1 0006", validD, pcD); end
    endtask

    task automatic test_flush_squash();
        delayAddr = 16'h0008; delayCycles = 3;
        do_reset();
        for (int i = 0; i < 4; i++) cyc();
        checks++; if ({validD, pcD} !== {1'b1, 16'h0006}) begin errors++;
            $display("FAIL flush_pre: v=%b pc=%h want 1 0006", validD, pcD); end
        cyc();
        flushD = 1'b1; branch_targetD = 16'h0040;
        cyc();
        checks++; if ({validD, instrD} !== {1'b0, 16'h0}) begin errors++;
            $display("FAIL flush_bubble: v=%b i=%h want 0 0000", validD, instrD); end
        flushD = 1'b0; #1;
        checks++; if ({mif.imem_req, mif.imem_addr} !== {1'b1, 16'h0008}) begin errors++;
            $display("FAIL squash_hold: req=%b addr=%h want 1 0008", mif.imem_req,
                     mif.imem_addr); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (validD !== 1'b0) begin errors++;
                $display("FAIL squash_drop[%0d]: v=%b pc=%h want v=0", i, validD, pcD); end
        end
        #1;
        checks++; if ({mif.imem_req, mif.imem_addr} !== {1'b1, 16'h0040}) begin errors++;
            $display("FAIL flush_redirect: req=%b addr=%h want 1 0040", mif.imem_req,
                     mif.imem_addr); end
        cyc();
        checks++; if ({validD, pcD, instrD} !== {1'b1, 16'h0040, mem[16'h20]}) begin errors++;
            $display("FAIL flush_target: v=%b pc=%h i=%h want 1 0040 %h", validD, pcD, instrD,
                     mem[16'h20]); end
        delayAddr = 16'hFFFF;
    endtask

    task automatic test_halt();
        logic [15:0] saved;
        saved = mem[6];
        mem[6] = 16'hF000;
        do_reset();
        for (int i = 0; i < 7; i++) cyc();
        checks++; if ({validD, pcD, instrD, haltF} !== {1'b1, 16'h000C, 16'hF000, 1'b1}) begin
            errors++;
            $display("FAIL halt_deliver: v=%b pc=%h i=%h halt=%b want 1 000c f000 1", validD, pcD,
                     instrD, haltF); end
        #1;
        checks++; if (mif.imem_req !== 1'b0) begin errors++;
            $display("FAIL halt_noreq: req=%b want 0", mif.imem_req); end
        cyc();
        checks++; if ({validD, haltF, mif.imem_req} !== 3'b010) begin errors++;
            $display("FAIL halt_drain: v=%b halt=%b req=%b want 0 1 0", validD, haltF,
                     mif.imem_req); end
        flushD = 1'b1; branch_targetD = 16'h0020;
        cyc();
        checks++; if ({validD, haltF} !== 2'b00) begin errors++;
            $display("FAIL halt_flush: v=%b halt=%b want 0 0", validD, haltF); end
        flushD = 1'b0; #1;
        checks++; if ({mif.imem_req, mif.imem_addr} !== {1'b1, 16'h0020}) begin errors++;
            $display("FAIL halt_resume: req=%b addr=%h want 1 0020", mif.imem_req,
                     mif.imem_addr); end
        cyc();
        checks++; if ({validD, pcD} !== {1'b1, 16'h0020}) begin errors++;
            $display("FAIL halt_resume_d: v=%b pc=%h want 1 0020", validD, pcD); end
        mem[6] = saved;
    endtask

    task automatic test_reset_mid_wait();
        delayAddr = 16'h0002; delayCycles = 3;
        do_reset();
        cyc(); cyc();
        rst_n = 1'b0; #1;
        checks++; if (mif.imem_req !== 1'b0) begin errors++;
            $display("FAIL rstmid_req: req=%b want 0", mif.imem_req); end
        cyc();
        checks++; if ({validD, haltF, instrD, pcD} !== 34'h0) begin errors++;
            $display("FAIL rstmid_out: v=%b halt=%b i=%h pc=%h want 0", validD, haltF, instrD,
                     pcD); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if ({perf_fetched, perf_bubbles} !== 64'h0) begin errors++;
            $display("FAIL rstmid_perf: %0d %0d want 0 0", perf_fetched, perf_bubbles); end
`endif
        rst_n = 1'b1; #1;
        checks++; if ({mif.imem_req, mif.imem_addr} !== {1'b1, 16'h0000}) begin errors++;
            $display("FAIL rstmid_pc: req=%b addr=%h want 1 0000", mif.imem_req, mif.imem_addr);
        end
        cyc();
        checks++; if ({validD, pcD} !== {1'b1, 16'h0000}) begin errors++;
            $display("FAIL rstmid_first: v=%b pc=%h want 1 0000", validD, pcD); end
        delayAddr = 16'hFFFF;
    endtask

    task automatic test_random();
        logic [15:0] expPc, prevAddr, prevTarget;
        logic [48:0] snap;
        logic        prevOut, prevStall, prevFlush;
        int          delivered = 0;
        randLat = 1'b1;
        do_reset();
        expPc = 16'h0000;
        prevOut = 1'b0;
        for (int c = 0; c < 600; c++) begin
            stallF = ($urandom_range(0, 4) == 0);
            stallD = ($urandom_range(0, 4) == 0);
            flushD = ($urandom_range(0, 11) == 0);
            branch_targetD = {7'h0, 8'($urandom), 1'b0};
            #1;
            if (prevOut) begin
                checks++;
                if ({mif.imem_req, mif.imem_addr} !== {1'b1, prevAddr}) begin errors++;
                    $display("FAIL rnd_hold c=%0d: req=%b addr=%h want 1 %h", c, mif.imem_req,
                             mif.imem_addr, prevAddr); end
            end
            prevOut = mif.imem_req && !mif.imem_rdy;
            prevAddr = mif.imem_addr;
            snap = {validD, instrD, pcD, pc_plus2D};
            prevStall = stallD; prevFlush = flushD; prevTarget = branch_targetD;
            cyc();
            if (prevFlush) begin
                checks++;
                if (validD !== 1'b0) begin errors++;
                    $display("FAIL rnd_flush c=%0d: v=%b want 0", c, validD); end
                expPc = prevTarget;
            end else if (prevStall) begin
                checks++;
                if ({validD, instrD, pcD, pc_plus2D} !== snap) begin errors++;
                    $display("FAIL rnd_stall c=%0d: got %h want %h", c,
                             {validD, instrD, pcD, pc_plus2D}, snap); end
            end else if (validD) begin
                checks++;
                if ({pcD, pc_plus2D, instrD} !== {expPc, 16'(expPc + 16'd2), mem[expPc[15:1]]})
                begin errors++;
                    $display("FAIL rnd_order c=%0d: pc=%h p2=%h i=%h want %h %h %h", c, pcD,
                             pc_plus2D, instrD, expPc, 16'(expPc + 16'd2), mem[expPc[15:1]]);
                end
                expPc = expPc + 16'd2;
                delivered++;
            end
        end
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        randLat = 1'b0;
        checks++; if (delivered < 50) begin errors++;
            $display("FAIL rnd_progress: delivered=%0d want >=50", delivered); end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_zero_wait();
        test_wait_state();
        test_stall_buffer();
        test_flush_squash();
        test_halt();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
